// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if: request/response bundle between the EX/LSU issue logic
// and the memory request queue.
//   req_*   : upstream request (valid/ready handshake, cmd, addr, data, size, tag)
//   resp_*  : one-cycle tagged completion pulse back to the requester
// master = issue logic side, slave = queue side.
interface mem_req_queue_if #(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_cmd;
    logic [XLEN-1:0]  req_addr;
    logic [63:0]      req_data;
    logic [2:0]       req_size;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_is_load;
    logic [TAG_W-1:0] resp_tag;
    logic [63:0]      resp_data;

    modport master (
        output req_valid, req_cmd, req_addr, req_data, req_size, req_tag,
        input  req_ready, resp_valid, resp_is_load, resp_tag, resp_data
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_data, req_size, req_tag,
        output req_ready, resp_valid, resp_is_load, resp_tag, resp_data
    );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order load/store FIFO in front of the dcache.
// Presents one request at a time on proc2Dcache_*, holds it until `finished`,
// then spends one NONE cycle (GAP) before the next. Loads get their lane
// extracted and sign/zero-extended from Dcache_data_out; every completed,
// non-flushed request produces a one-cycle tagged response.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   bus (slave)         : req_* handshake in, resp_* completion out
//   flush               : drop all queued entries not currently in flight
//   proc2Dcache_*       : command/addr/data/size to dcache (0 outside ISSUE)
//   Dcache_data_out     : doubleword holding the addressed bytes
//   Dcache_valid_out    : informational, not used
//   finished            : dcache completed the current request
//   count               : FIFO occupancy
//   timeout_err         : sticky stall flag (optional)
// Optional feature macro: MEM_REQ_QUEUE_TIMEOUT_EN enables a 10-bit ISSUE
// watchdog driving timeout_err; otherwise timeout_err is tied to 0.
module mem_req_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_req_queue_if.slave           bus,
    input  logic                     flush,
    output logic [1:0]               proc2Dcache_command,
    output logic [XLEN-1:0]          proc2Dcache_addr,
    output logic [63:0]              proc2Dcache_data,
    output logic [2:0]               proc2Dcache_size,
    input  logic [63:0]              Dcache_data_out,
    input  logic                     Dcache_valid_out,
    input  logic                     finished,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [1:0] CMD_LOAD = 2'd1, CMD_STORE = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state;

    logic [1:0]       q_cmd  [DEPTH];
    logic [XLEN-1:0]  q_addr [DEPTH];
    logic [63:0]      q_data [DEPTH];
    logic [2:0]       q_size [DEPTH];
    logic [TAG_W-1:0] q_tag  [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic             squashed;   // in-flight request was flushed; swallow its response

    wire unused_dcache_valid = Dcache_valid_out;

    assign bus.req_ready = (count < DEPTH_C);

    wire enq = bus.req_valid && bus.req_ready && !flush &&
               (bus.req_cmd == CMD_LOAD || bus.req_cmd == CMD_STORE);
    wire pop = (state == ISSUE) && finished;

    // Load lane extraction from the head entry (the one in flight).
    logic [63:0] lane, load_ext;
    logic [2:0]  h_size;
    always_comb begin
        h_size   = q_size[head];
        lane     = Dcache_data_out >> {q_addr[head][2:0], 3'b000};
        load_ext = lane;
        case (h_size[1:0])
            2'd0: load_ext = h_size[2] ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1: load_ext = h_size[2] ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2: load_ext = h_size[2] ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // Entry storage needs no reset; validity is tracked by head/tail/count.
    always_ff @(posedge clock) begin
        if (enq) begin
            q_cmd[tail]  <= bus.req_cmd;
            q_addr[tail] <= bus.req_addr;
            q_data[tail] <= bus.req_data;
            q_size[tail] <= bus.req_size;
            q_tag[tail]  <= bus.req_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            squashed            <= 1'b0;
            proc2Dcache_command <= '0;
            proc2Dcache_addr    <= '0;
            proc2Dcache_data    <= '0;
            proc2Dcache_size    <= '0;
            bus.resp_valid      <= 1'b0;
            bus.resp_is_load    <= 1'b0;
            bus.resp_tag        <= '0;
            bus.resp_data       <= '0;
        end else begin
            // Occupancy and pointers. A flush keeps only the in-flight head,
            // and only while it has not completed this same cycle.
            if (flush) begin
                if (state == ISSUE) begin
                    head  <= head + PTR_W'(pop);
                    tail  <= head + PTR_W'(1);
                    count <= pop ? '0 : (PTR_W+1)'(1);
                end else begin
                    tail  <= head;
                    count <= '0;
                end
            end else begin
                if (enq) tail <= tail + PTR_W'(1);
                if (pop) head <= head + PTR_W'(1);
                count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
            end

            bus.resp_valid <= 1'b0;

            case (state)
                IDLE, GAP: begin
                    // In GAP the head pointer already reflects the pop.
                    if (count != '0 && !flush) begin
                        state               <= ISSUE;
                        squashed            <= 1'b0;
                        proc2Dcache_command <= q_cmd[head];
                        proc2Dcache_addr    <= q_addr[head];
                        proc2Dcache_data    <= q_data[head];
                        proc2Dcache_size    <= q_size[head];
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (flush) squashed <= 1'b1;
                    if (finished) begin
                        state               <= GAP;
                        proc2Dcache_command <= '0;
                        proc2Dcache_addr    <= '0;
                        proc2Dcache_data    <= '0;
                        proc2Dcache_size    <= '0;
                        bus.resp_valid      <= !(squashed || flush);
                        bus.resp_is_load    <= (q_cmd[head] == CMD_LOAD);
                        bus.resp_tag        <= q_tag[head];
                        bus.resp_data       <= (q_cmd[head] == CMD_LOAD) ? load_ext : 64'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    // Watchdog: counter holds at 0 outside ISSUE, so it restarts on every
    // entry. The flag rises in the ISSUE cycle whose count is 1023.
    logic [9:0] to_cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == ISSUE) begin
            if (to_cnt != 10'd1023) to_cnt <= to_cnt + 10'd1;
            if (to_cnt == 10'd1022) timeout_err <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed, table-driven check of mem_req_queue.
// Single-transaction vectors cover load extraction and stores; hand-written
// sequences cover back-to-back issue with the NONE gap, full queue, flush,
// drop of NONE/reserved commands, reset mid-ISSUE and the optional watchdog.
module tb_mem_req_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  proc2Dcache_command;
    logic [31:0] proc2Dcache_addr;
    logic [63:0] proc2Dcache_data;
    logic [2:0]  proc2Dcache_size;
    logic [63:0] Dcache_data_out;
    logic        Dcache_valid_out;
    logic        finished;
    logic [2:0]  count;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    mem_req_queue_if #(.TAG_W(5), .XLEN(32)) bus ();

    mem_req_queue #(.DEPTH(4), .TAG_W(5), .XLEN(32)) dut (
        .clock(clock), .reset(reset), .bus(bus), .flush(flush),
        .proc2Dcache_command(proc2Dcache_command), .proc2Dcache_addr(proc2Dcache_addr),
        .proc2Dcache_data(proc2Dcache_data), .proc2Dcache_size(proc2Dcache_size),
        .Dcache_data_out(Dcache_data_out), .Dcache_valid_out(Dcache_valid_out),
        .finished(finished), .count(count), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [4:0]  tag;
        logic [63:0] dword;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [63:0] data, input logic [2:0] size, input logic [4:0] tag);
        bus.req_cmd  = cmd;
        bus.req_addr = addr;
        bus.req_data = data;
        bus.req_size = size;
        bus.req_tag  = tag;
    endtask

    task automatic push(input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] data, input logic [2:0] size, input logic [4:0] tag);
        set_req(cmd, addr, data, size, tag);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (proc2Dcache_command == 2'd0 && n < 20) begin
            step();
            n++;
        end
        check(name, 64'(proc2Dcache_command != 2'd0), 64'd1);
    endtask

    task automatic complete(input logic [63:0] dword);
        Dcache_data_out  = dword;
        Dcache_valid_out = 1'b1;
        finished         = 1'b1;
        step();
        finished         = 1'b0;
        Dcache_valid_out = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd1, 32'h13,  3'd0, 64'h0, 5'd1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{2'd1, 32'h13,  3'd4, 64'h0, 5'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
        vecs[2] = '{2'd1, 32'h816, 3'd1, 64'h0, 5'd3, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF};
        vecs[3] = '{2'd1, 32'h816, 3'd5, 64'h0, 5'd4, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
        vecs[4] = '{2'd1, 32'h4,   3'd2, 64'h0, 5'd5, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
        vecs[5] = '{2'd1, 32'h4,   3'd6, 64'h0, 5'd6, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
        vecs[6] = '{2'd1, 32'h8,   3'd3, 64'h0, 5'd7, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[7] = '{2'd1, 32'h7,   3'd1, 64'h0, 5'd8, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB};
        vecs[8] = '{2'd1, 32'h1,   3'd0, 64'h0, 5'd9, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F};
        vecs[9] = '{2'd2, 32'h20,  3'd2, 64'h1111, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

        reset = 1'b1; flush = 1'b0; finished = 1'b0;
        Dcache_data_out = '0; Dcache_valid_out = 1'b0;
        bus.req_valid = 1'b0;
        set_req(2'd0, 32'h0, 64'h0, 3'd0, 5'd0);
        step(); step();
        reset = 1'b0;
        step();

        check("rst_count",   64'(count), 64'd0);
        check("rst_ready",   64'(bus.req_ready), 64'd1);
        check("rst_cmd",     64'(proc2Dcache_command), 64'd0);
        check("rst_resp",    64'(bus.resp_valid), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);

        // NONE and reserved commands are dropped.
        push(2'd0, 32'h40, 64'h0, 3'd0, 5'd1);
        push(2'd3, 32'h40, 64'h0, 3'd0, 5'd1);
        check("drop_count", 64'(count), 64'd0);
        step();
        check("drop_cmd", 64'(proc2Dcache_command), 64'd0);

        // Single-transaction vectors.
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].tag);
            check($sformatf("v%0d_pending", i), 64'(proc2Dcache_command), 64'd0);
            wait_issue($sformatf("v%0d_issue", i));
            check($sformatf("v%0d_cmd", i),  64'(proc2Dcache_command), 64'(vecs[i].cmd));
            check($sformatf("v%0d_addr", i), 64'(proc2Dcache_addr), 64'(vecs[i].addr));
            check($sformatf("v%0d_size", i), 64'(proc2Dcache_size), 64'(vecs[i].size));
            complete(vecs[i].dword);
            check($sformatf("v%0d_rvalid", i), 64'(bus.resp_valid), 64'd1);
            check($sformatf("v%0d_rtag", i),   64'(bus.resp_tag), 64'(vecs[i].tag));
            check($sformatf("v%0d_rload", i),  64'(bus.resp_is_load), 64'(vecs[i].cmd == 2'd1));
            check($sformatf("v%0d_rdata", i),  bus.resp_data, vecs[i].exp);
            step();
            check($sformatf("v%0d_rpulse", i), 64'(bus.resp_valid), 64'd0);
            check($sformatf("v%0d_count", i),  64'(count), 64'd0);
        end

        // Store then load: two requests with exactly one NONE cycle between.
        push(2'd2, 32'h10, 64'hFFFF_1234_4321_FFFF, 3'd3, 5'd3);
        push(2'd1, 32'h10, 64'h0, 3'd3, 5'd4);
        wait_issue("sl_issue1");
        check("sl_cmd1",  64'(proc2Dcache_command), 64'd2);
        check("sl_data1", proc2Dcache_data, 64'hFFFF_1234_4321_FFFF);
        step();
        check("sl_hold",  64'(proc2Dcache_command), 64'd2);
        complete(64'h0);
        check("sl_gap",    64'(proc2Dcache_command), 64'd0);
        check("sl_rtag1",  64'(bus.resp_tag), 64'd3);
        check("sl_rload1", 64'(bus.resp_is_load), 64'd0);
        check("sl_rdata1", bus.resp_data, 64'd0);
        step();
        check("sl_cmd2",   64'(proc2Dcache_command), 64'd1);
        check("sl_addr2",  64'(proc2Dcache_addr), 64'h10);
        check("sl_data2z", proc2Dcache_data, 64'd0);
        complete(64'hFFFF_1234_4321_FFFF);
        check("sl_rvalid2", 64'(bus.resp_valid), 64'd1);
        check("sl_rtag2",   64'(bus.resp_tag), 64'd4);
        check("sl_rdata2",  bus.resp_data, 64'hFFFF_1234_4321_FFFF);
        step();
        check("sl_idle", 64'(count), 64'd0);

        // Full queue: 5 back-to-back offers with finished held low.
        set_req(2'd1, 32'h200, 64'h0, 3'd2, 5'd10);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req_tag = 5'(10 + i);
            step();
            if (i == 3) begin
                check("full_ready4", 64'(bus.req_ready), 64'd0);
                check("full_count4", 64'(count), 64'd4);
            end
        end
        bus.req_valid = 1'b0;
        check("full_count5", 64'(count), 64'd4);
        complete(64'h0);
        check("full_count_pop", 64'(count), 64'd3);
        check("full_ready_pop", 64'(bus.req_ready), 64'd1);
        check("full_rtag",      64'(bus.resp_tag), 64'd10);
        step();
        check("full_reissue", 64'(proc2Dcache_command), 64'd1);

        // Reset while a request is in ISSUE.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_cmd",   64'(proc2Dcache_command), 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        step();

        // Flush with tag 1 in flight and two more queued.
        bus.req_valid = 1'b1;
        set_req(2'd1, 32'h100, 64'h0, 3'd3, 5'd1); step();
        bus.req_tag = 5'd2; bus.req_addr = 32'h108; step();
        bus.req_tag = 5'd3; bus.req_addr = 32'h110; step();
        check("fl_count3", 64'(count), 64'd3);
        bus.req_tag = 5'd7; bus.req_addr = 32'h118;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        check("fl_count1",  64'(count), 64'd1);
        check("fl_inflight", 64'(proc2Dcache_addr), 64'h100);
        complete(64'h0);
        check("fl_noresp", 64'(bus.resp_valid), 64'd0);
        check("fl_count0", 64'(count), 64'd0);
        step();
        check("fl_idle_cmd", 64'(proc2Dcache_command), 64'd0);
        step();
        check("fl_stay_idle", 64'(proc2Dcache_command), 64'd0);

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        push(2'd1, 32'h300, 64'h0, 3'd3, 5'd20);
        wait_issue("to_issue");
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (k == 1000) check("to_early", 64'(timeout_err), 64'd0);
            if (k == 1023) check("to_at1023", 64'(timeout_err), 64'd1);
        end
        check("to_set", 64'(timeout_err), 64'd1);
        complete(64'h0);
        step();
        check("to_sticky", 64'(timeout_err), 64'd1);
`else
        check("to_tied0", 64'(timeout_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
